seg_scan_driver: RTL

//  Consumes the two 9-bit per-digit segment words from the 24 s countdown counter and time-multiplexes them

---
 rtl/seg_scan_pkg.sv | 34 +++
 rtl/seg_blink_gen.sv | 40 ++++
 rtl/seg_scan_driver.sv | 111 +++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the two-digit segment scan driver: scan states,
// segment-word field positions and all-off constants.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      BLANK0 = 2'd0,
      DIG0   = 2'd1,
      BLANK1 = 2'd2,
      DIG1   = 2'd3
   } scan_state_t;

   localparam int          SEG_OFF_BIT  = 8;
   localparam int          SEG_DP_BIT   = 7;
   localparam logic [7:0]  SEG_ALL_OFF  = 8'h00;
   localparam logic [1:0]  DIG_ALL_OFF  = 2'b11;
   localparam logic [8:0]  SEG_WORD_OFF = 9'h100;

   // Active-low digit select for a scan state; a blank request keeps both off.
   function automatic logic [1:0] dig_sel_for(input scan_state_t st, input logic blank);
      logic [1:0] sel;
      case (st)
         DIG0:    sel = 2'b10;
         DIG1:    sel = 2'b01;
         default: sel = DIG_ALL_OFF;
      endcase
      if (blank) begin
         sel = DIG_ALL_OFF;
      end else begin
         sel = sel;
      end
      return sel;
   endfunction

endpackage

// File: rtl/seg_blink_gen.sv
// Timeout blink phase generator: half-period counter plus visible/dark phase flop.
// Only instantiated when SEG_BLINK_EN is defined.
module seg_blink_gen
   import seg_scan_pkg::*;
#(
   parameter int CLK_HZ   = 12000000,
   parameter int BLINK_HZ = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic blink_req,
   output logic visible
);

   localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
   localparam int CW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

   logic [CW-1:0] blink_cnt_r;
   logic          phase_r;

   // Dropping the request snaps straight back to visible with a fresh count.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_r <= '0;
         phase_r     <= 1'b1;
      end else if (!blink_req) begin
         blink_cnt_r <= '0;
         phase_r     <= 1'b1;
      end else if (blink_cnt_r == CNT_LAST) begin
         blink_cnt_r <= '0;
         phase_r     <= ~phase_r;
      end else begin
         blink_cnt_r <= blink_cnt_r + CW'(1);
      end
   end

   assign visible = phase_r;

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit common-bus segment scanner with anti-ghosting blank gaps and
// snapshot-per-slot digit data. Optional timeout blink via macro SEG_BLINK_EN.
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int CLK_HZ    = 12000000,
   parameter int SCAN_HZ   = 1000,
   parameter int GHOST_CYC = 12,
   parameter int BLINK_HZ  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] in_seg_1,
   input  logic [8:0] in_seg_2,
   input  logic       blink_req,
   output logic [7:0] seg_out,
   output logic [1:0] dig_sel_n,
   output logic       frame_tick
);

   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int CW       = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] GHOST_LAST = CW'(GHOST_CYC - 1);

   scan_state_t   state_r, state_nxt_s;
   logic [CW-1:0] slot_cnt_r;
   logic [8:0]    hold_r;
   logic          vis_r;
   logic          phase_s;
   logic          slot_end_s, ghost_end_s, snap_s;
   logic [8:0]    snap_word_s;
   logic [7:0]    seg_nxt_s;
   logic [1:0]    dig_nxt_s;
   logic          tick_nxt_s;

`ifdef SEG_BLINK_EN
   seg_blink_gen #(
      .CLK_HZ   (CLK_HZ),
      .BLINK_HZ (BLINK_HZ)
   ) u_blink (
      .clk       (clk),
      .rst       (rst),
      .blink_req (blink_req),
      .visible   (phase_s)
   );
`else
   logic unused_blink_req_s;
   assign unused_blink_req_s = blink_req;
   assign phase_s            = 1'b1;
`endif

   assign slot_end_s  = (slot_cnt_r == SLOT_LAST);
   assign ghost_end_s = (slot_cnt_r == GHOST_LAST);
   assign snap_s      = ghost_end_s && ((state_r == BLANK0) || (state_r == BLANK1));
   assign snap_word_s = (state_r == BLANK0) ? in_seg_1 : in_seg_2;

   // Next scan state and the pin values the current state calls for.
   always_comb begin
      state_nxt_s = state_r;
      seg_nxt_s   = SEG_ALL_OFF;
      dig_nxt_s   = DIG_ALL_OFF;
      tick_nxt_s  = 1'b0;
      case (state_r)
         BLANK0: begin
            if (ghost_end_s) state_nxt_s = DIG0;
            else             state_nxt_s = BLANK0;
         end
         BLANK1: begin
            if (ghost_end_s) state_nxt_s = DIG1;
            else             state_nxt_s = BLANK1;
         end
         DIG0, DIG1: begin
            dig_nxt_s = dig_sel_for(state_r, hold_r[SEG_OFF_BIT]);
            if (vis_r && !hold_r[SEG_OFF_BIT]) seg_nxt_s = hold_r[SEG_DP_BIT:0];
            else                               seg_nxt_s = SEG_ALL_OFF;
            if (slot_end_s) begin
               state_nxt_s = (state_r == DIG0) ? BLANK1 : BLANK0;
               tick_nxt_s  = (state_r == DIG1);
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: state_nxt_s = BLANK0;
      endcase
   end

   // Slot timing, digit snapshot and registered pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= BLANK0;
         slot_cnt_r <= '0;
         hold_r     <= SEG_WORD_OFF;
         vis_r      <= 1'b1;
         seg_out    <= SEG_ALL_OFF;
         dig_sel_n  <= DIG_ALL_OFF;
         frame_tick <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         slot_cnt_r <= slot_end_s ? '0 : slot_cnt_r + CW'(1);
         if (snap_s) begin
            hold_r <= snap_word_s;
            vis_r  <= phase_s;
         end
         seg_out    <= seg_nxt_s;
         dig_sel_n  <= dig_nxt_s;
         frame_tick <= tick_nxt_s;
      end
   end

endmodule
